// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, sequencer states and default width.
// Used by both the sequencer and the ALU sitting beside it.
package alu_pkg;

  localparam int N_DEF = 16;

  typedef enum logic [1:0] {
    OP_SUMA    = 2'b00,
    OP_SHIFT_D = 2'b01,
    OP_RESTA   = 2'b10,
    OP_SHIFT_I = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer for an external ALU: latch operands, capture the
// result one cycle later, hold it until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_opa,
  input  logic [N-1:0] i_opb,
  input  logic         i_use_acc,
  input  logic         i_clr_acc,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [1:0]   o_alu_control,
  input  logic [N-1:0] i_alu_q,
  input  logic         i_alu_mayor,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_carry,
  output logic         o_parity,
  output logic [N-1:0] o_acc,
  output logic [7:0]   o_count
);

  seq_state_e state;
  seq_state_e state_nxt;

  logic accept;
  logic take;

  assign accept = (state == IDLE) && i_valid;
  assign take   = (state == DONE) && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_valid) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state alone, never on the inputs.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): o_ready = 1'b1;
      (state == DONE): o_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_control <= '0;
      o_result      <= '0;
      o_carry       <= 1'b0;
      o_parity      <= 1'b0;
      o_acc         <= '0;
      o_count       <= '0;
    end else begin
      // Operand A samples the accumulator before any same-edge clear.
      if (accept) begin
        o_alu_a       <= i_use_acc ? o_acc : i_opa;
        o_alu_b       <= i_opb;
        o_alu_control <= i_op;
      end
      if (state == EXEC) begin
        o_result <= i_alu_q;
        o_acc    <= i_alu_q;
        o_parity <= i_alu_q[0];
        o_carry  <= (o_alu_control == OP_SUMA)
                    ? i_alu_mayor : 1'b0;
      end else if (i_clr_acc) begin
        o_acc <= '0;
      end
      if (take) o_count <= o_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU beside it
// and a scoreboard of expected results.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int N = 16;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_op;
  logic [N-1:0] i_opa;
  logic [N-1:0] i_opb;
  logic         i_use_acc;
  logic         i_clr_acc;
  logic [N-1:0] o_alu_a;
  logic [N-1:0] o_alu_b;
  logic [1:0]   o_alu_control;
  logic [N-1:0] i_alu_q;
  logic         i_alu_mayor;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic         o_carry;
  logic         o_parity;
  logic [N-1:0] o_acc;
  logic [7:0]   o_count;

  alu_sequencer #(.N(N)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_op          (i_op),
    .i_opa         (i_opa),
    .i_opb         (i_opb),
    .i_use_acc     (i_use_acc),
    .i_clr_acc     (i_clr_acc),
    .o_alu_a       (o_alu_a),
    .o_alu_b       (o_alu_b),
    .o_alu_control (o_alu_control),
    .i_alu_q       (i_alu_q),
    .i_alu_mayor   (i_alu_mayor),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_result      (o_result),
    .o_carry       (o_carry),
    .o_parity      (o_parity),
    .o_acc         (o_acc),
    .o_count       (o_count)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural ALU; it raises mayor for every op so carry gating is visible.
  always_comb begin
    i_alu_q     = '0;
    i_alu_mayor = 1'b0;
    case (o_alu_control)
      2'b00: {i_alu_mayor, i_alu_q} = {1'b0, o_alu_a} + {1'b0, o_alu_b};
      2'b10: {i_alu_mayor, i_alu_q} = {1'b0, o_alu_a} - {1'b0, o_alu_b};
      2'b01: {i_alu_mayor, i_alu_q} = {o_alu_a[0], 1'b0, o_alu_a[N-1:1]};
      default: {i_alu_mayor, i_alu_q} = {o_alu_a, 1'b0};
    endcase
  end

  typedef struct packed {
    logic [N-1:0] q;
    logic         c;
    logic         p;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [N-1:0] macc;
  logic [7:0]   mcnt;
  logic [N-1:0] r;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [N:0] ref_alu(input logic [1:0] op,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N-1:0] t;
    case (op)
      2'b00: return {1'b0, a} + {1'b0, b};
      2'b10: begin t = a - b; return {1'b0, t}; end
      2'b01: begin t = a >> 1; return {1'b0, t}; end
      default: begin t = a << 1; return {1'b0, t}; end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op,
                       input logic [N-1:0] a,
                       input logic [N-1:0] b,
                       input logic ua,
                       input logic clr,
                       input int hold,
                       output logic [N-1:0] res);
    logic [N-1:0] ae;
    logic [N:0]   rr;
    exp_t         e;
    exp_t         g;
    int           lat;
    @(negedge i_clk);
    chk("ready", o_ready, 1);
    i_valid   = 1'b1;
    i_op      = op;
    i_opa     = a;
    i_opb     = b;
    i_use_acc = ua;
    i_clr_acc = clr;
    ae = ua ? macc : a;
    rr = ref_alu(op, ae, b);
    e.q = rr[N-1:0];
    e.c = rr[N];
    e.p = rr[0];
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("alu_a", o_alu_a, ae);
    chk("alu_b", o_alu_b, b);
    chk("alu_ctl", o_alu_control, op);
    lat = 1;
    while (!o_valid && lat < 8) begin
      @(posedge i_clk);
      #1;
      i_clr_acc = 1'b0;
      lat++;
    end
    i_clr_acc = 1'b0;
    chk("latency", lat, 2);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      g = e;
    end else begin
      g = sb.pop_front();
    end
    chk("result", o_result, g.q);
    chk("carry", o_carry, g.c);
    chk("parity", o_parity, g.p);
    chk("acc", o_acc, g.q);
    macc = g.q;
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      i_valid = i[0] ? 1'b0 : 1'b1;
      i_opa   = N'($urandom);
      i_op    = 2'($urandom);
      @(posedge i_clk);
      #1;
      chk("hold_res", o_result, g.q);
      chk("hold_rdy", o_ready, 0);
      chk("hold_vld", o_valid, 1);
      chk("hold_a", o_alu_a, ae);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    mcnt++;
    chk("count", o_count, mcnt);
    chk("idle_vld", o_valid, 0);
    res = g.q;
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_op      = '0;
    i_opa     = '0;
    i_opb     = '0;
    i_use_acc = 1'b0;
    i_clr_acc = 1'b0;
    i_ready   = 1'b0;
    macc      = '0;
    mcnt      = '0;
    #12;
    chk("rst_rdy", o_ready, 1);
    chk("rst_vld", o_valid, 0);
    chk("rst_acc", o_acc, 0);
    chk("rst_cnt", o_count, 0);
    chk("rst_res", o_result, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    do_op(2'b00, 16'h0003, 16'h0004, 1'b0, 1'b0, 0, r);
    chk("add_res", o_result, 16'h0007);
    chk("add_c", o_carry, 0);
    chk("add_p", o_parity, 1);
    chk("add_acc", o_acc, 16'h0007);
    chk("add_cnt", o_count, 1);

    do_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, r);
    chk("ovf_res", o_result, 16'h0000);
    chk("ovf_c", o_carry, 1);
    chk("ovf_p", o_parity, 0);

    do_op(2'b11, 16'h8001, 16'h0000, 1'b0, 1'b0, 0, r);
    chk("shl_res", o_result, 16'h0002);
    chk("shl_c", o_carry, 0);
    do_op(2'b01, 16'h1234, 16'h0000, 1'b1, 1'b0, 0, r);
    chk("shr_res", o_result, 16'h0001);
    chk("shr_c", o_carry, 0);

    do_op(2'b10, 16'h0003, 16'h0004, 1'b0, 1'b0, 5, r);
    chk("sub_res", o_result, 16'hFFFF);
    chk("sub_c", o_carry, 0);

    @(negedge i_clk);
    i_clr_acc = 1'b1;
    @(posedge i_clk);
    #1;
    i_clr_acc = 1'b0;
    chk("clr_idle", o_acc, 0);
    macc = '0;

    do_op(2'b00, 16'h0005, 16'h0000, 1'b0, 1'b0, 0, r);
    do_op(2'b00, 16'h0000, 16'h0002, 1'b1, 1'b1, 0, r);
    chk("clr_pre", o_result, 16'h0007);

    // Abandon an operation mid-flight with reset.
    @(negedge i_clk);
    i_valid = 1'b1;
    i_op    = 2'b00;
    i_opa   = 16'h0011;
    i_opb   = 16'h0022;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("ar_rdy", o_ready, 1);
    chk("ar_vld", o_valid, 0);
    chk("ar_acc", o_acc, 0);
    chk("ar_cnt", o_count, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    macc = '0;
    mcnt = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk);
      #1;
      chk("ar_novld", o_valid, 0);
    end
    chk("ar_cnt2", o_count, 0);

    for (int i = 0; i < 256; i++) begin
      do_op(2'($urandom_range(0, 3)), N'($urandom), N'($urandom),
            1'($urandom), 1'b0, 0, r);
    end
    chk("wrap", o_count, 8'h00);
    chk("sb_left", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
